lcd_read: RTL and testbench
===========================

Name: lcd_read

Overview:
- Read-side engine for the HD44780-compatible character LCD: the counterpart of the existing write path, performing RW=1 bus cycles.
- Reads either the busy flag plus address counter (RS=0) or DDRAM/CGRAM data at the current address (RS=1).
- Optional busy-flag polling mode lets the write path wait for real LCD readiness instead of fixed delays.
- Shares LCD_DATA/LCD_RS/LCD_RW/LCD_EN with the writer through a request/grant handshake to the LCD top-level mux.

Parameters:
- T_AS, 3, cycles of RS/RW setup before EN rises (≥40 ns at 50 MHz)
- T_EN, 13, cycles EN held high (≥230 ns; covers tDDR 160 ns)
- T_HOLD, 2, cycles after EN falls with RS/RW held
- T_REC, 12, cycles EN low before next EN rise or release (tcycE ≥500 ns total)
- MAX_POLLS, 255, busy-flag reads before timeout; 8-bit counter

Ports:
- iCLK  in  1  50 MHz system clock
- iRST  in  1  synchronous, active-high reset
- iSTART  in  1  request one read transaction; sampled only in IDLE
- iRS  in  1  0 = busy flag/address read, 1 = data read; latched at iSTART
- iPOLL  in  1  1 = repeat reads until BF=0; latched at iSTART; honoured only when iRS=0
- oBUSY  out  1  high from iSTART acceptance until oDONE cycle inclusive
- oDONE  out  1  one-cycle pulse at transaction end
- oDATA  out  8  last captured byte; held until next capture
- oBF  out  1  oDATA[7]
- oADDR  out  7  oDATA[6:0]
- oTIMEOUT  out  1  set with oDONE when poll limit hit; cleared at next accepted iSTART
- oBUS_REQ  out  1  bus request to LCD mux
- iBUS_GNT  in  1  bus grant from LCD mux
- LCD_DATA  inout  8  always high-Z from this block; sampled only
- LCD_RW  out  1  1 from SETUP entry through RECOV; else 0
- LCD_EN  out  1  high only in EN_HI
- LCD_RS  out  1  latched iRS while bus held; else 0

Behaviour:
- Reset: all outputs 0, state IDLE, LCD_DATA released. Takes effect on the edge where iRST=1, including mid-transaction; EN drops that edge and the partial read is discarded. No oDONE is produced for an aborted transaction.
- States:
  - IDLE: iSTART=1 latches iRS/iPOLL, clears oTIMEOUT, goes to REQ.
  - REQ: oBUS_REQ=1; waits indefinitely for iBUS_GNT=1, then goes to SETUP.
  - SETUP: lasts T_AS cycles.
  - EN_HI: lasts T_EN cycles; LCD_DATA is captured into oDATA on the final EN_HI edge, the same edge EN falls.
  - HOLD: lasts T_HOLD cycles.
  - RECOV: lasts T_REC cycles. Goes to SETUP if polling, latched iRS=0, captured BF=1 and poll count < MAX_POLLS; otherwise goes to DONE.
  - DONE: oDONE=1, oBUS_REQ=0, back to IDLE the next cycle.
- oBUS_REQ stays high from REQ through DONE-1, so the bus is held across poll iterations.
- Latency with grant already high: oDONE asserts 1+T_AS+T_EN+T_HOLD+T_REC+1 = 32 cycles after the iSTART sampling edge; each extra poll adds 30 cycles.
- iSTART outside IDLE is ignored.
- iBUS_GNT dropping after REQ is a mux protocol error; the transaction completes regardless.
- Poll counter: 8-bit, cleared at iSTART, incremented per completed read; saturates at MAX_POLLS.
- Back-to-back: iSTART in the cycle after oDONE is accepted.

Optional Feature:
- LCD_READ_POLL_TIMEOUT_EN
  - Defined: MAX_POLLS limit enforced; on hitting the limit with BF still 1, go to DONE with oTIMEOUT=1.
  - Undefined: polling is unbounded, the counter is absent, and oTIMEOUT is tied 0.

Decomposition:
- lcd_pkg: state encoding, T_AS/T_EN/T_HOLD/T_REC defaults, BF bit index (7), address field width (7).
- One sub-module, lcd_phase_timer: down-counter loaded per state entry that raises a terminal-count strobe.

Test Plan:
- Grant tied high; iRS=1, LCD model drives 8'h41 → LCD_EN high for exactly 13 cycles, oDATA=8'h41, oDONE 32 cycles after iSTART, LCD_RW=0 after.
- iRS=0, iPOLL=1, model returns BF=1 for 3 reads then 8'h05 → 4 EN pulses, oBF=0, oADDR=7'h05, oDONE at cycle 122, oTIMEOUT=0.
- Macro defined, MAX_POLLS=4, BF stuck at 1 → exactly 4 EN pulses, oTIMEOUT=1 with oDONE; next iSTART clears oTIMEOUT.
- iBUS_GNT held low 20 cycles after iSTART → oBUS_REQ=1, LCD_EN=0, LCD_RW=0 throughout the wait; then normal 31-cycle completion.
- iRST=1 during EN_HI → next edge LCD_EN=0, oBUS_REQ=0, oBUSY=0, no oDONE, oDATA keeps its prior value.
- Throughout all scenarios → LCD_DATA never driven by this block; LCD_RW=1 at least 3 cycles before every LCD_EN rise.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared types and timing defaults for the HD44780 character-LCD read engine.
package lcd_pkg;

    localparam int unsigned T_AS_DEF      = 3;
    localparam int unsigned T_EN_DEF      = 13;
    localparam int unsigned T_HOLD_DEF    = 2;
    localparam int unsigned T_REC_DEF     = 12;
    localparam int unsigned MAX_POLLS_DEF = 255;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned BF_BIT = 7;
    localparam int unsigned ADDR_W = 7;
    localparam int unsigned TMR_W  = 8;
    localparam int unsigned POLL_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_SETUP,
        ST_EN_HI,
        ST_HOLD,
        ST_RECOV,
        ST_DONE
    } state_t;

    // States in which RW/RS are actually driven onto the granted bus.
    function automatic logic bus_phase(state_t s);
        return (s == ST_SETUP) || (s == ST_EN_HI) || (s == ST_HOLD) || (s == ST_RECOV);
    endfunction

endpackage

// File: rtl/lcd_phase_timer.sv
// Per-phase down-counter: loaded on state entry, tc_c high once the phase has run its length.
module lcd_phase_timer
    import lcd_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [TMR_W-1:0] load_val,
    output logic             tc_c
);

    logic [TMR_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - TMR_W'(1);
        end
    end

    assign tc_c = (cnt == '0);

endmodule

// File: rtl/lcd_read.sv
// HD44780 read engine (RW=1 cycles) with optional busy-flag polling.
// Define LCD_READ_POLL_TIMEOUT_EN to bound polling by MAX_POLLS and report oTIMEOUT.
module lcd_read
    import lcd_pkg::*;
#(
    parameter int unsigned T_AS   = T_AS_DEF,
    parameter int unsigned T_EN   = T_EN_DEF,
    parameter int unsigned T_HOLD = T_HOLD_DEF,
    parameter int unsigned T_REC  = T_REC_DEF
`ifdef LCD_READ_POLL_TIMEOUT_EN
    ,
    parameter int unsigned MAX_POLLS = MAX_POLLS_DEF
`endif
) (
    input  logic              iCLK,
    input  logic              iRST,
    input  logic              iSTART,
    input  logic              iRS,
    input  logic              iPOLL,
    output logic              oBUSY,
    output logic              oDONE,
    output logic [DATA_W-1:0] oDATA,
    output logic              oBF,
    output logic [ADDR_W-1:0] oADDR,
    output logic              oTIMEOUT,
    output logic              oBUS_REQ,
    input  logic              iBUS_GNT,
    inout  wire  [DATA_W-1:0] LCD_DATA,
    output logic              LCD_RW,
    output logic              LCD_EN,
    output logic              LCD_RS
);

    state_t            state, state_nxt;
    logic              rs_q, poll_q;
    logic [DATA_W-1:0] data_q;
    logic              load_c, tc_c, capture_c, accept_c, more_c;
    logic [TMR_W-1:0]  load_val_c;

    assign LCD_DATA  = {DATA_W{1'bz}};
    assign accept_c  = (state == ST_IDLE) && iSTART;
    assign capture_c = (state == ST_EN_HI) && tc_c;

    lcd_phase_timer u_timer (
        .clk      (iCLK),
        .rst      (iRST),
        .load     (load_c),
        .load_val (load_val_c),
        .tc_c     (tc_c)
    );

    // Next state plus timer reload on every state entry.
    always_comb begin
        state_nxt  = state;
        load_c     = 1'b0;
        load_val_c = '0;
        case (state)
            ST_IDLE:  if (iSTART)   state_nxt = ST_REQ;
            ST_REQ:   if (iBUS_GNT) state_nxt = ST_SETUP;
            ST_SETUP: if (tc_c)     state_nxt = ST_EN_HI;
            ST_EN_HI: if (tc_c)     state_nxt = ST_HOLD;
            ST_HOLD:  if (tc_c)     state_nxt = ST_RECOV;
            ST_RECOV: if (tc_c)     state_nxt = more_c ? ST_SETUP : ST_DONE;
            ST_DONE:                state_nxt = ST_IDLE;
            default:                state_nxt = ST_IDLE;
        endcase
        if (state_nxt != state) begin
            load_c = 1'b1;
            case (state_nxt)
                ST_SETUP: load_val_c = TMR_W'(T_AS - 1);
                ST_EN_HI: load_val_c = TMR_W'(T_EN - 1);
                ST_HOLD:  load_val_c = TMR_W'(T_HOLD - 1);
                ST_RECOV: load_val_c = TMR_W'(T_REC - 1);
                default:  load_val_c = '0;
            endcase
        end
    end

    // Outputs are registered from the next state so they line up with the state register.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state    <= ST_IDLE;
            rs_q     <= 1'b0;
            poll_q   <= 1'b0;
            oBUSY    <= 1'b0;
            oDONE    <= 1'b0;
            oBUS_REQ <= 1'b0;
            LCD_RW   <= 1'b0;
            LCD_EN   <= 1'b0;
            LCD_RS   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept_c) begin
                rs_q   <= iRS;
                poll_q <= iPOLL;
            end
            oBUSY    <= (state_nxt != ST_IDLE);
            oDONE    <= (state_nxt == ST_DONE);
            oBUS_REQ <= (state_nxt == ST_REQ) || bus_phase(state_nxt);
            LCD_RW   <= bus_phase(state_nxt);
            LCD_EN   <= (state_nxt == ST_EN_HI);
            LCD_RS   <= bus_phase(state_nxt) && (accept_c ? iRS : rs_q);
        end
    end

    // The last good byte survives a reset; an aborted read never overwrites it.
    always_ff @(posedge iCLK) begin
        if (!iRST && capture_c) begin
            data_q <= LCD_DATA;
        end
    end

    assign oDATA = data_q;
    assign oBF   = data_q[BF_BIT];
    assign oADDR = data_q[ADDR_W-1:0];

`ifdef LCD_READ_POLL_TIMEOUT_EN
    logic [POLL_W-1:0] polls_q;
    logic              timeout_q;

    assign more_c = poll_q && !rs_q && data_q[BF_BIT] && (polls_q < POLL_W'(MAX_POLLS));

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            polls_q   <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (accept_c) begin
                polls_q <= '0;
            end else if (capture_c && (polls_q != POLL_W'(MAX_POLLS))) begin
                polls_q <= polls_q + POLL_W'(1);
            end
            // Reaching DONE with BF still set while polling can only mean the limit hit.
            if (accept_c) begin
                timeout_q <= 1'b0;
            end else if ((state == ST_RECOV) && tc_c && !more_c
                         && poll_q && !rs_q && data_q[BF_BIT]) begin
                timeout_q <= 1'b1;
            end
        end
    end

    assign oTIMEOUT = timeout_q;
`else
    assign more_c   = poll_q && !rs_q && data_q[BF_BIT];
    assign oTIMEOUT = 1'b0;
`endif

endmodule

// File: tb/tb_lcd_read.sv
// Directed self-checking bench for lcd_read; LCD model answers reads while RW is high.
module tb_lcd_read;

    logic       iCLK = 1'b0;
    logic       iRST, iSTART, iRS, iPOLL, iBUS_GNT;
    logic       oBUSY, oDONE, oBF, oTIMEOUT, oBUS_REQ;
    logic [7:0] oDATA;
    logic [6:0] oADDR;
    logic       LCD_RW, LCD_EN, LCD_RS;
    wire  [7:0] LCD_DATA;

    int checks = 0;
    int errors = 0;

    // LCD model: first n_busy reads of a transaction return busy_val, later ones final_val.
    logic [7:0] busy_val  = 8'h00;
    logic [7:0] final_val = 8'h00;
    int         n_busy     = 0;
    int         pulse_base = 0;

    // Bus monitor state (written only by the monitor process).
    int   pulses      = 0;
    int   en_run      = 0;
    int   rw_run      = 0;
    int   en_bad      = 0;
    int   en_len_last = 0;
    int   rw_min      = 1000;
    int   done_cnt    = 0;
    logic en_prev     = 1'b0;

    assign LCD_DATA = LCD_RW ? (((pulses - pulse_base) < n_busy) ? busy_val : final_val)
                             : 8'hzz;

    always #10 iCLK = ~iCLK;

    lcd_read #(
        .T_AS   (3),
        .T_EN   (13),
        .T_HOLD (2),
        .T_REC  (12)
`ifdef LCD_READ_POLL_TIMEOUT_EN
        ,
        .MAX_POLLS (4)
`endif
    ) dut (
        .iCLK     (iCLK),
        .iRST     (iRST),
        .iSTART   (iSTART),
        .iRS      (iRS),
        .iPOLL    (iPOLL),
        .oBUSY    (oBUSY),
        .oDONE    (oDONE),
        .oDATA    (oDATA),
        .oBF      (oBF),
        .oADDR    (oADDR),
        .oTIMEOUT (oTIMEOUT),
        .oBUS_REQ (oBUS_REQ),
        .iBUS_GNT (iBUS_GNT),
        .LCD_DATA (LCD_DATA),
        .LCD_RW   (LCD_RW),
        .LCD_EN   (LCD_EN),
        .LCD_RS   (LCD_RS)
    );

    always @(negedge iCLK) begin
        if (LCD_EN && !en_prev && (rw_run < rw_min)) rw_min = rw_run;
        if (!LCD_EN && en_prev) begin
            pulses      = pulses + 1;
            en_len_last = en_run;
            if (en_run != 13) en_bad = en_bad + 1;
        end
        en_run  = LCD_EN ? en_run + 1 : 0;
        rw_run  = LCD_RW ? rw_run + 1 : 0;
        if (oDONE) done_cnt = done_cnt + 1;
        en_prev = LCD_EN;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic start_read(input logic rs, input logic poll);
        @(negedge iCLK);
        iSTART = 1'b1;
        iRS    = rs;
        iPOLL  = poll;
        @(posedge iCLK);
        #1;
        iSTART = 1'b0;
        iRS    = 1'b0;
        iPOLL  = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int n);
        n = 0;
        do begin
            @(negedge iCLK);
            n++;
        end while (!oDONE && (n < budget));
        check("done_seen", 32'(oDONE), 32'd1);
    endtask

    task automatic set_model(input int nb, input logic [7:0] bv, input logic [7:0] fv);
        n_busy     = nb;
        busy_val   = bv;
        final_val  = fv;
        pulse_base = pulses;
    endtask

    initial begin
        int n, bad, dc, k;
        iRST = 1'b1; iSTART = 1'b0; iRS = 1'b0; iPOLL = 1'b0; iBUS_GNT = 1'b1;
        repeat (3) @(posedge iCLK);
        @(negedge iCLK);
        check("reset_outs", 32'({oBUSY, oDONE, oTIMEOUT, oBUS_REQ, LCD_EN, LCD_RW, LCD_RS}), 32'd0);
        iRST = 1'b0;

        // Data read; a stray iSTART mid-transaction must be ignored.
        set_model(0, 8'h00, 8'h41);
        start_read(1'b1, 1'b0);
        @(negedge iCLK);
        check("req_cycle", 32'({oBUSY, oBUS_REQ, LCD_RW}), 32'b110);
        iSTART = 1'b1; iRS = 1'b0; iPOLL = 1'b1;
        @(negedge iCLK);
        check("setup_rs", 32'({LCD_RW, LCD_RS, LCD_EN}), 32'b110);
        @(negedge iCLK);
        iSTART = 1'b0; iPOLL = 1'b0;
        wait_done(100, n);
        check("data_latency", 32'(n + 3), 32'd32);
        check("data_byte", 32'(oDATA), 32'h41);
        check("done_outs", 32'({oBUSY, oBUS_REQ, LCD_RW, LCD_EN}), 32'b1000);
        check("data_pulses", 32'(pulses - pulse_base), 32'd1);
        check("en_width", 32'(en_len_last), 32'd13);
        @(negedge iCLK);
        check("after_done", 32'({oBUSY, oDONE}), 32'b00);

        // Busy-flag polling: three busy reads then address 5.
        set_model(3, 8'h85, 8'h05);
        start_read(1'b0, 1'b1);
        wait_done(400, n);
        check("poll_latency", 32'(n), 32'd122);
        check("poll_pulses", 32'(pulses - pulse_base), 32'd4);
        check("poll_bf", 32'(oBF), 32'd0);
        check("poll_addr", 32'(oADDR), 32'h05);
        check("poll_timeout", 32'(oTIMEOUT), 32'd0);

        // Back-to-back start; iPOLL with iRS=1 must not repeat even though bit 7 is set.
        set_model(0, 8'h00, 8'hA5);
        start_read(1'b1, 1'b1);
        wait_done(100, n);
        check("b2b_latency", 32'(n), 32'd32);
        check("b2b_pulses", 32'(pulses - pulse_base), 32'd1);
        check("b2b_bf_addr", 32'({oBF, oADDR}), 32'({1'b1, 7'h25}));

`ifdef LCD_READ_POLL_TIMEOUT_EN
        // Busy flag stuck: limit of four reads then timeout.
        set_model(1000, 8'h80, 8'h80);
        start_read(1'b0, 1'b1);
        wait_done(400, n);
        check("to_latency", 32'(n), 32'd122);
        check("to_pulses", 32'(pulses - pulse_base), 32'd4);
        check("to_flag", 32'({oTIMEOUT, oBF}), 32'b11);
        set_model(0, 8'h00, 8'h12);
        start_read(1'b1, 1'b0);
        @(negedge iCLK);
        check("to_cleared", 32'(oTIMEOUT), 32'd0);
        wait_done(100, n);
        check("to_next_latency", 32'(n + 1), 32'd32);
        check("to_next_data", 32'(oDATA), 32'h12);
`endif

        // Grant withheld for 20 cycles.
        set_model(0, 8'h00, 8'h3C);
        iBUS_GNT = 1'b0;
        start_read(1'b1, 1'b0);
        bad = 0;
        repeat (20) begin
            @(negedge iCLK);
            if (!(oBUS_REQ && !LCD_EN && !LCD_RW)) bad++;
        end
        check("gnt_wait", 32'(bad), 32'd0);
        iBUS_GNT = 1'b1;
        wait_done(100, n);
        check("gnt_latency", 32'(n), 32'd31);
        check("gnt_data", 32'(oDATA), 32'h3C);

        // Reset in the middle of EN_HI.
        set_model(0, 8'h00, 8'h77);
        start_read(1'b1, 1'b0);
        k = 0;
        while (!LCD_EN && (k < 20)) begin
            @(negedge iCLK);
            k++;
        end
        check("en_seen", 32'(LCD_EN), 32'd1);
        repeat (4) @(negedge iCLK);
        iRST = 1'b1;
        dc   = done_cnt;
        @(negedge iCLK);
        check("abort_outs", 32'({LCD_EN, oBUS_REQ, oBUSY, oDONE, LCD_RW}), 32'd0);
        check("abort_data", 32'(oDATA), 32'h3C);
        iRST = 1'b0;
        repeat (40) @(negedge iCLK);
        check("abort_no_done", 32'(done_cnt), 32'(dc));
        check("abort_data_kept", 32'(oDATA), 32'h3C);

        // Normal read after the abort.
        set_model(0, 8'h00, 8'h5A);
        start_read(1'b1, 1'b0);
        wait_done(100, n);
        check("recover_latency", 32'(n), 32'd32);
        check("recover_data", 32'(oDATA), 32'h5A);

        check("rw_setup_min", 32'(rw_min), 32'd3);
        check("short_en_pulses", 32'(en_bad), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
